// File: rtl/mic1_run_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module : mic1_run_ctrl_if
// Brief  : Command/status bundle between the debouncer side and mic1_run_ctrl
// Rev    : 1.0
// ============================================================================
interface mic1_run_ctrl_if #(
   parameter int CYC_W = 16
);
   logic             start_stop;
   logic             step;
   logic             speed_up;
   logic             speed_down;
   logic             halt;
   logic             cpu_ce;
   logic             running;
   logic [3:0]       led_speed;
   logic [CYC_W-1:0] cycle_count;

   modport master (
      output start_stop, step, speed_up, speed_down, halt,
      input  cpu_ce, running, led_speed, cycle_count
   );

   modport slave (
      input  start_stop, step, speed_up, speed_down, halt,
      output cpu_ce, running, led_speed, cycle_count
   );
endinterface
`default_nettype wire

// File: rtl/mic1_run_ctrl.sv
`default_nettype none
// ============================================================================
// Module : mic1_run_ctrl
// Brief  : Run/step controller producing the MIC-1 core clock enable
// Rev    : 1.0
// ============================================================================
module mic1_run_ctrl #(
   parameter int BASE_DIV = 4,
   parameter int CNT_W    = 16,
   parameter int CYC_W    = 16
) (
   input wire              clk,
   input wire              reset,
   mic1_run_ctrl_if.slave  bus
);

   typedef enum logic [0:0] {
      ST_STOP = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   localparam logic [CNT_W-1:0] c_base_div = CNT_W'(BASE_DIV);

   state_t           r_state;
   state_t           w_state_nxt;
   logic [1:0]       r_spd;
   logic [1:0]       w_spd_nxt;
   logic             w_spd_chg;
   logic [CNT_W-1:0] r_presc;
   logic [CNT_W-1:0] w_presc_nxt;
   logic [CNT_W-1:0] w_period_m1;
   logic             r_cpu_ce;
   logic             w_cpu_ce_nxt;
   logic [3:0]       r_led_speed;
   logic [CYC_W-1:0] r_cycle_count;

   // Period is BASE_DIV << 2*(3-spd); for a 2-bit spd, 3-spd equals ~spd.
   assign w_period_m1 = (c_base_div << {~r_spd, 1'b0}) - CNT_W'(1);

   always_comb begin
      w_spd_nxt = r_spd;
      if (bus.speed_up && !bus.speed_down && (r_spd != 2'd3)) begin
         w_spd_nxt = r_spd + 2'd1;
      end else if (bus.speed_down && !bus.speed_up && (r_spd != 2'd0)) begin
         w_spd_nxt = r_spd - 2'd1;
      end
      w_spd_chg = (w_spd_nxt != r_spd);
   end

   always_comb begin
      w_state_nxt  = r_state;
      w_presc_nxt  = r_presc;
      w_cpu_ce_nxt = 1'b0;
      case (r_state)
         ST_STOP: begin
            w_presc_nxt = '0;
            // A start command takes priority over a coincident step.
            if (bus.start_stop && !bus.halt) begin
               w_state_nxt = ST_RUN;
            end else if (bus.step) begin
               w_cpu_ce_nxt = 1'b1;
            end
         end
         ST_RUN: begin
            if (bus.start_stop || bus.halt) begin
               w_state_nxt = ST_STOP;
               w_presc_nxt = '0;
            end else if (w_spd_chg) begin
               w_presc_nxt = '0;
            end else if (r_presc == w_period_m1) begin
               w_presc_nxt  = '0;
               w_cpu_ce_nxt = 1'b1;
            end else begin
               w_presc_nxt = r_presc + CNT_W'(1);
            end
         end
         default: begin
            w_state_nxt = ST_STOP;
            w_presc_nxt = '0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state       <= ST_STOP;
         r_spd         <= 2'd0;
         r_presc       <= '0;
         r_cpu_ce      <= 1'b0;
         r_led_speed   <= 4'b0001;
         r_cycle_count <= '0;
      end else begin
         r_state     <= w_state_nxt;
         r_spd       <= w_spd_nxt;
         r_presc     <= w_presc_nxt;
         r_cpu_ce    <= w_cpu_ce_nxt;
         r_led_speed <= 4'b0001 << w_spd_nxt;
         if (r_cpu_ce) begin
            r_cycle_count <= r_cycle_count + CYC_W'(1);
         end
      end
   end

   assign bus.cpu_ce      = r_cpu_ce;
   assign bus.running     = (r_state == ST_RUN);
   assign bus.led_speed   = r_led_speed;
   assign bus.cycle_count = r_cycle_count;

endmodule
`default_nettype wire

// File: tb/tb_mic1_run_ctrl.sv
`default_nettype none
// ============================================================================
// Module : tb_mic1_run_ctrl
// Brief  : Directed bench with a pulse-time scoreboard for mic1_run_ctrl
// Rev    : 1.0
// ============================================================================
module tb_mic1_run_ctrl;
   localparam int CYC_W = 4;

   logic clk   = 1'b0;
   logic reset = 1'b1;
   int   cyc   = 0;
   int   exp_q[$];
   int   n_checks = 0;
   int   n_fail   = 0;
   int   n_issued = 0;

   mic1_run_ctrl_if #(.CYC_W(CYC_W)) bus ();

   mic1_run_ctrl #(
      .BASE_DIV (4),
      .CNT_W    (16),
      .CYC_W    (CYC_W)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic expect_pulse(input int c);
      exp_q.push_back(c);
      n_issued++;
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Drive one-cycle command pulses; s returns the index of the sampling edge.
   task automatic cmd(input logic ss, input logic st, input logic up,
                      input logic dn, output int s);
      bus.start_stop = ss;
      bus.step       = st;
      bus.speed_up   = up;
      bus.speed_down = dn;
      tick(1);
      s = cyc;
      bus.start_stop = 1'b0;
      bus.step       = 1'b0;
      bus.speed_up   = 1'b0;
      bus.speed_down = 1'b0;
   endtask

   always @(negedge clk) begin
      if (!reset && bus.cpu_ce) begin
         if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_ce: pulse at cycle %0d, none expected", cyc);
         end else begin
            int e;
            e = exp_q.pop_front();
            check("ce_cycle", cyc, e);
         end
      end
   end

   initial begin
      int s;
      int d;
      logic [3:0] led_exp [5];
      led_exp = '{4'b0010, 4'b0100, 4'b1000, 4'b1000, 4'b1000};

      bus.start_stop = 1'b0;
      bus.step       = 1'b0;
      bus.speed_up   = 1'b0;
      bus.speed_down = 1'b0;
      bus.halt       = 1'b0;

      tick(3);
      check("rst_ce", bus.cpu_ce, 0);
      check("rst_running", bus.running, 0);
      check("rst_led", bus.led_speed, 4'b0001);
      check("rst_count", bus.cycle_count, 0);
      reset = 1'b0;
      tick(2);

      // Single steps while stopped
      for (int i = 0; i < 3; i++) begin
         cmd(1'b0, 1'b1, 1'b0, 1'b0, s);
         expect_pulse(s);
         tick(9);
      end
      check("step_count", bus.cycle_count, 3);
      check("step_running", bus.running, 0);

      // Speed up with saturation at 3
      for (int i = 0; i < 5; i++) begin
         cmd(1'b0, 1'b0, 1'b1, 1'b0, s);
         check("led_up", bus.led_speed, led_exp[i]);
      end

      // Run at P=4 for 40 cycles
      cmd(1'b1, 1'b0, 1'b0, 1'b0, s);
      check("run_entry", bus.running, 1);
      for (int k = 1; k <= 10; k++) expect_pulse(s + 4 * k);
      tick(40);

      // Slow down to P=16; simultaneous up+down must not disturb spacing
      cmd(1'b0, 1'b0, 1'b0, 1'b1, d);
      check("led_down", bus.led_speed, 4'b0100);
      for (int k = 1; k <= 4; k++) expect_pulse(d + 16 * k);
      tick(32);
      cmd(1'b0, 1'b0, 1'b1, 1'b1, s);
      check("led_both", bus.led_speed, 4'b0100);
      tick(31);
      tick(2);
      check("run_count", bus.cycle_count, n_issued % 16);

      // Halt stops the run; start is ignored, step still works
      bus.halt = 1'b1;
      tick(1);
      check("halt_running", bus.running, 0);
      tick(20);
      cmd(1'b1, 1'b0, 1'b0, 1'b0, s);
      check("halt_start_ignored", bus.running, 0);
      cmd(1'b0, 1'b1, 1'b0, 1'b0, s);
      expect_pulse(s);
      tick(3);
      check("halt_step_count", bus.cycle_count, n_issued % 16);
      bus.halt = 1'b0;

      // Start and step together: start wins, first pulse after P=16
      cmd(1'b1, 1'b1, 1'b0, 1'b0, s);
      check("start_step_running", bus.running, 1);
      check("start_step_no_ce", bus.cpu_ce, 0);
      expect_pulse(s + 16);
      tick(16);
      cmd(1'b1, 1'b0, 1'b0, 1'b0, s);
      check("stop_running", bus.running, 0);
      tick(20);

      // Counter wrap with a 4-bit cycle_count
      for (int i = 0; i < 17; i++) begin
         cmd(1'b0, 1'b1, 1'b0, 1'b0, s);
         expect_pulse(s);
         tick(2);
      end
      tick(2);
      check("wrap_count", bus.cycle_count, n_issued % 16);

      // Asynchronous reset while a pulse is high in RUN
      cmd(1'b0, 1'b0, 1'b1, 1'b0, s);
      check("led_spd3", bus.led_speed, 4'b1000);
      cmd(1'b1, 1'b0, 1'b0, 1'b0, s);
      expect_pulse(s + 4);
      tick(8);
      check("ce_before_reset", bus.cpu_ce, 1);
      #2;
      reset = 1'b1;
      #1;
      check("async_rst_ce", bus.cpu_ce, 0);
      check("async_rst_running", bus.running, 0);
      check("async_rst_led", bus.led_speed, 4'b0001);
      check("async_rst_count", bus.cycle_count, 0);
      tick(2);
      check("queue_empty", exp_q.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
`default_nettype wire
